// File: rtl/pkt_fifo_pkg.sv
// pkt_fifo_pkg: shared types, entry layout and pointer sizing for the packet FIFO
package pkt_fifo_pkg;
  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} wr_state_t;
  // flag positions counted above the payload bits of an entry {sop, eop, data}
  localparam int SOP_BIT = 1;
  localparam int EOP_BIT = 0;
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/pkt_fifo_if.sv
// pkt_fifo_if: write/read handshake and status bundle of the packet FIFO
interface pkt_fifo_if import pkt_fifo_pkg::*; #(
  parameter int fifo_data_width = 256,
  parameter int fifo_depth = 16
);
  localparam int pw = ptr_width(fifo_depth);
  logic wr_vld;
  logic wr_sop;
  logic wr_eop;
  logic [fifo_data_width-1:0] wr_data;
  logic read;
  logic sop;
  logic eop;
  logic vld;
  logic [fifo_data_width-1:0] out_data;
  logic pkt_avail;
  logic full;
  logic empty;
  logic [pw-1:0] level;
  logic drop;
  logic err;
  modport master (
    output wr_vld, wr_sop, wr_eop, wr_data, read,
    input sop, eop, vld, out_data, pkt_avail, full, empty, level, drop, err
  );
  modport slave (
    input wr_vld, wr_sop, wr_eop, wr_data, read,
    output sop, eop, vld, out_data, pkt_avail, full, empty, level, drop, err
  );
endinterface

// File: rtl/pkt_fifo_ram.sv
// fifo_ram: simple dual-port memory, one write port and one registered read port
module fifo_ram #(
  parameter int width = 258,
  parameter int depth = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [$clog2(depth)-1:0] waddr,
  input  logic [width-1:0] wdata,
  input  logic re,
  input  logic [$clog2(depth)-1:0] raddr,
  output logic [width-1:0] rdata
);
  logic [width-1:0] mem [depth];
  // storage array, never cleared
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register holds its value between pops
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/pkt_fifo.sv
// pkt_fifo: packet-aware FIFO exposing only complete packets, with overflow rollback
module pkt_fifo import pkt_fifo_pkg::*; #(
  parameter int fifo_data_width = 256,
  parameter int fifo_depth = 16
) (
  input logic clk,
  input logic rst,
  pkt_fifo_if.slave bus
);
  localparam int fifo_addr_width = $clog2(fifo_depth);
  localparam int pw = ptr_width(fifo_depth);
  localparam int ew = fifo_data_width + 2;
  wr_state_t state, state_n;
  logic [pw-1:0] wr_ptr, rd_ptr, wr_start, wr_ptr_n, wr_start_n, waddr, pkt_cnt, lvl;
  logic we, commit, drop_n, err_n, rd_fire, pop_eop, full_i, vld_r, drop_r, err_r;
  logic [fifo_depth-1:0] eop_mark;
  logic [ew-1:0] rdata;
  assign lvl = wr_ptr - rd_ptr;
  assign full_i = lvl == pw'(fifo_depth);
  assign rd_fire = bus.read && pkt_cnt != '0;
  assign pop_eop = rd_fire && eop_mark[rd_ptr[fifo_addr_width-1:0]];
  // write-side decision: where to write, pointer moves, commit/drop/err for this word
  always_comb begin
    state_n = state;
    wr_ptr_n = wr_ptr;
    wr_start_n = wr_start;
    waddr = wr_ptr;
    we = 1'b0;
    commit = 1'b0;
    drop_n = 1'b0;
    err_n = 1'b0;
    if (bus.wr_vld) begin
      if (state == IN_PKT && full_i) begin
        wr_ptr_n = wr_start;
        drop_n = 1'b1;
        state_n = bus.wr_eop ? IDLE : DROP;
      end else if (state == IN_PKT && bus.wr_sop) begin
        err_n = 1'b1;
        we = 1'b1;
        waddr = wr_start;
        wr_ptr_n = wr_start + 1'b1;
        wr_start_n = bus.wr_eop ? wr_start + 1'b1 : wr_start;
        commit = bus.wr_eop;
        state_n = bus.wr_eop ? IDLE : IN_PKT;
      end else if (state == IN_PKT) begin
        we = 1'b1;
        wr_ptr_n = wr_ptr + 1'b1;
        wr_start_n = bus.wr_eop ? wr_ptr + 1'b1 : wr_start;
        commit = bus.wr_eop;
        state_n = bus.wr_eop ? IDLE : IN_PKT;
      end else if (!bus.wr_sop) begin
        err_n = state == IDLE;
        state_n = bus.wr_eop ? IDLE : state;
      end else if (full_i) begin
        drop_n = 1'b1;
        err_n = state == DROP;
        state_n = bus.wr_eop ? IDLE : DROP;
      end else begin
        we = 1'b1;
        err_n = state == DROP;
        wr_ptr_n = wr_ptr + 1'b1;
        wr_start_n = bus.wr_eop ? wr_ptr + 1'b1 : wr_ptr;
        commit = bus.wr_eop;
        state_n = bus.wr_eop ? IDLE : IN_PKT;
      end
    end
  end
  // control state, pointers, packet count and registered pulses
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      wr_start <= '0;
      pkt_cnt <= '0;
      vld_r <= 1'b0;
      drop_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state <= state_n;
      wr_ptr <= wr_ptr_n;
      wr_start <= wr_start_n;
      rd_ptr <= rd_fire ? rd_ptr + 1'b1 : rd_ptr;
      pkt_cnt <= pkt_cnt + pw'(commit) - pw'(pop_eop);
      vld_r <= rd_fire;
      drop_r <= drop_n;
      err_r <= err_n;
    end
  // eop shadow so the pop decision knows packet boundaries without a read delay
  always_ff @(posedge clk)
    if (we) eop_mark[waddr[fifo_addr_width-1:0]] <= bus.wr_eop;
  fifo_ram #(.width(ew), .depth(fifo_depth)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(waddr[fifo_addr_width-1:0]),
    .wdata({bus.wr_sop, bus.wr_eop, bus.wr_data}),
    .re(rd_fire),
    .raddr(rd_ptr[fifo_addr_width-1:0]),
    .rdata(rdata)
  );
  assign bus.vld = vld_r;
  assign bus.sop = vld_r & rdata[fifo_data_width+SOP_BIT];
  assign bus.eop = vld_r & rdata[fifo_data_width+EOP_BIT];
  assign bus.out_data = rdata[fifo_data_width-1:0];
  assign bus.pkt_avail = pkt_cnt != '0;
  assign bus.full = full_i;
  assign bus.empty = lvl == '0;
  assign bus.level = lvl;
  assign bus.drop = drop_r;
  assign bus.err = err_r;
endmodule

// File: doc/pkt_fifo.md
Name: pkt_fifo

Overview:
Parametrised packet-aware FIFO, the successor to the fixed 8-entry, 256-bit priority queue FIFO. It stores words tagged with sop/eop and exposes only complete packets to the reader. It rolls back and drops packets that overflow, and flags framing errors. One instance sits per priority queue in front of the SRAM write path of sram_ctl.

Parameters:
fifo_data_width, 256, payload bits per word
fifo_depth, 16, word entries; power of 2, ≥ 4
fifo_addr_width, $clog2(fifo_depth), localparam, not overridable

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_vld  in  1  write word valid
wr_sop  in  1  first word of packet (qualified by wr_vld)
wr_eop  in  1  last word of packet (qualified by wr_vld)
wr_data  in  fifo_data_width  write payload
read  in  1  pop one word
sop  out  1  output word is packet start
eop  out  1  output word is packet end
vld  out  1  out_data valid this cycle
out_data  out  fifo_data_width  read payload
pkt_avail  out  1  at least one complete packet stored
full  out  1  level == fifo_depth
empty  out  1  level == 0
level  out  fifo_addr_width+1  words stored, committed plus in-progress
drop  out  1  one-cycle pulse: packet dropped on overflow
err  out  1  one-cycle pulse: framing error

Behaviour:
- Reset (clk edge with rst=1):
  - Pointers, pkt_cnt and level are 0; state is IDLE.
  - sop, eop, vld, drop and err are 0; out_data is 0. Memory is not cleared.
  - Reset mid-packet discards all contents.
- Storage: entry = {sop, eop, data}.
  - wr_ptr, rd_ptr and wr_start are fifo_addr_width+1 bits and wrap modulo 2*fifo_depth.
  - level = wr_ptr - rd_ptr.
  - full and empty use pointer values registered before the current cycle, so a same-cycle read does not free space for a write.
- Write FSM:
  - IDLE:
    - wr_vld & wr_sop & !full: write the word at wr_ptr; wr_start <= wr_ptr; wr_ptr++.
    - If wr_eop is also set: commit (pkt_cnt++, wr_start <= wr_ptr+1) and stay IDLE; otherwise go to IN_PKT.
    - wr_vld & !wr_sop: word discarded, err pulse.
    - wr_vld & wr_sop & full: drop pulse. Go to DROP, or stay IDLE if wr_eop.
  - IN_PKT:
    - wr_vld & !wr_sop & !full: write and wr_ptr++. On wr_eop: commit and go to IDLE.
    - wr_vld & full: wr_ptr <= wr_start (rollback), drop pulse. Go to DROP, or IDLE if wr_eop.
    - wr_vld & wr_sop: err pulse; the partial packet is abandoned and the new sop word is written at wr_start. wr_ptr <= wr_start+1; stay IN_PKT, or commit if wr_eop.
  - DROP: all words ignored. wr_vld & wr_eop goes to IDLE. wr_vld & wr_sop is treated as in IDLE, with an err pulse.
  - A packet longer than fifo_depth is always dropped.
- Read:
  - read & pkt_cnt>0: next cycle vld=1, out_data/sop/eop = entry[rd_ptr]; rd_ptr++.
  - If the popped entry has eop: pkt_cnt--.
  - read with pkt_cnt==0: ignored; vld=0 next cycle.
  - Latency: read to vld is exactly 1 cycle; back-to-back reads give one word per cycle.
  - When vld=0: sop=eop=0 and out_data holds its last value.
- pkt_avail = (pkt_cnt != 0).
- Simultaneous commit and eop pop: pkt_cnt unchanged.
- Rollback never moves wr_ptr below rd_ptr, because reads only touch committed words.
- Simultaneous rollback and read: level reflects both.

Decomposition:
- Package pkt_fifo_pkg:
  - write-state enum {IDLE, IN_PKT, DROP};
  - entry bit-position constants (SOP_BIT, EOP_BIT);
  - a function computing pointer width from depth.
- Sub-module fifo_ram: simple dual-port memory (1 write, 1 registered read), depth/width parametrised. Control logic stays in pkt_fifo.

Test Plan:
1. Reset, then write 3-word packet A0..A2 (sop on A0, eop on A2), then read 3 consecutive cycles -> vld=1 on each following cycle, sop with A0, eop with A2; level 3→0; pkt_avail 1→0.
2. Write sop word B0 only, then assert read -> vld stays 0 and pkt_avail=0. After the B1 eop word, a read returns B0 one cycle later.
3. Commit a 10-word packet, then write an 8-word packet -> words 1..6 accepted (level 16), 7th word drops: drop pulse, level back to 10, 8th word ignored, state IDLE. The next 4-word packet is accepted (level 14).
4. pkt_cnt=1 with the reader popping its eop word in the same cycle an incoming eop commits -> pkt_avail remains 1, pkt_cnt=1.
5. Write C0(sop), C1, then D0(sop), D1(eop) -> err pulse on D0 cycle, level=2. Reading returns D0(sop), D1(eop) only.
6. rst asserted mid-packet with 5 words stored -> next cycle level=0, empty=1, vld=sop=eop=0. A fresh 2-word packet then reads back correctly.
